// File: rtl/counter_cu_pkg.sv
// rtl/counter_cu_pkg.sv - shared state encodings and defaults for the counter control unit
package counter_cu_pkg;

   localparam int STATE_W           = 2;
   localparam int DB_CYCLES_DEFAULT = 100_000;

   typedef enum logic [STATE_W-1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } cu_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stability-window debouncer and press pulse
module btn_debounce
   import counter_cu_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DB_CYCLES);

   logic          sync1;
   logic          sync2;
   logic          level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= btn_in;
         sync2   <= sync1;
         level_d <= level;
         // Registered edge detect puts the pulse one cycle after the level rises.
         press   <= level & ~level_d;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_control_unit.sv
// rtl/counter_control_unit.sv - run/stop/clear FSM and up/down mode driven by debounced buttons
// Optional MODE_LOCK_EN: mode pulses only honoured while stopped.
module counter_control_unit
   import counter_cu_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_run,
   input  logic               btn_clear,
   input  logic               btn_mode,
   output logic               enable,
   output logic               clear,
   output logic               mode,
   output logic [STATE_W-1:0] state
);

   cu_state_t  state_q;
   logic       run_press;
   logic       clear_press;
   logic       mode_press;
   logic [2:0] btn_level;
   logic       mode_ok;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_run),
      .level  (btn_level[0]),
      .press  (run_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_clear),
      .level  (btn_level[1]),
      .press  (clear_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_mode),
      .level  (btn_level[2]),
      .press  (mode_press)
   );

`ifdef MODE_LOCK_EN
   assign mode_ok = (state_q == ST_STOP);
`else
   assign mode_ok = 1'b1;
`endif

   assign state = state_q;

   // enable/clear are loaded alongside the next state so they match it exactly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_STOP;
         enable  <= 1'b0;
         clear   <= 1'b0;
         mode    <= 1'b0;
      end else begin
         case (state_q)
            ST_STOP: begin
               if (clear_press) begin
                  state_q <= ST_CLEAR;
                  enable  <= 1'b0;
                  clear   <= 1'b1;
               end else if (run_press) begin
                  state_q <= ST_RUN;
                  enable  <= 1'b1;
                  clear   <= 1'b0;
               end else begin
                  state_q <= ST_STOP;
                  enable  <= 1'b0;
                  clear   <= 1'b0;
               end
            end
            ST_RUN: begin
               clear <= 1'b0;
               if (run_press) begin
                  state_q <= ST_STOP;
                  enable  <= 1'b0;
               end else begin
                  state_q <= ST_RUN;
                  enable  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               state_q <= ST_STOP;
               enable  <= 1'b0;
               clear   <= 1'b0;
            end
            default: begin
               state_q <= ST_STOP;
               enable  <= 1'b0;
               clear   <= 1'b0;
            end
         endcase
         if (mode_press && mode_ok) begin
            mode <= ~mode;
         end
      end
   end

endmodule

// File: tb/tb_counter_control_unit.sv
// tb/tb_counter_control_unit.sv - directed self-checking bench for counter_control_unit (DB_CYCLES=4)
module tb_counter_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_run = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_mode = 1'b0;
   logic       enable;
   logic       clear;
   logic       mode;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   counter_control_unit #(.DB_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_run   (btn_run),
      .btn_clear (btn_clear),
      .btn_mode  (btn_mode),
      .enable    (enable),
      .clear     (clear),
      .mode      (mode),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edge_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic next_sample();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   logic exp_mode;

   initial begin
      #2;
      chk("rst_enable", {7'd0, enable}, 8'd0);
      chk("rst_clear",  {7'd0, clear},  8'd0);
      chk("rst_mode",   {7'd0, mode},   8'd0);
      chk("rst_state",  {6'd0, state},  8'd0);
      chk("rst_run_level", {7'd0, dut.u_run.level}, 8'd0);
      idle(3);
      rst = 1'b1;

      for (int i = 0; i < 50; i++) begin
         next_sample();
         chk("idle_outputs", {3'd0, enable, clear, mode, state}, 8'd0);
      end

      // Clean run press: pulse 7 cycles after the input edge, enable the cycle after.
      edge_drive();
      btn_run = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         next_sample();
         chk("run_press_pulse", {7'd0, dut.run_press}, {7'd0, (i == 7)});
         chk("run_enable",      {7'd0, enable},        {7'd0, (i >= 8)});
         chk("run_state",       {6'd0, state},         (i >= 8) ? 8'd1 : 8'd0);
      end
      edge_drive();
      btn_run = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         next_sample();
         chk("release_no_pulse", {7'd0, dut.run_press}, 8'd0);
         chk("release_enable",   {7'd0, enable},        8'd1);
      end
      edge_drive();
      btn_run = 1'b1;
      idle(12);
      @(negedge clk);
      chk("stop_enable", {7'd0, enable}, 8'd0);
      chk("stop_state",  {6'd0, state},  8'd0);
      edge_drive();
      btn_run = 1'b0;
      idle(10);

      // Bounce shorter than the window never settles.
      for (int i = 0; i < 10; i++) begin
         btn_run = ~btn_run;
         for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("bounce_no_pulse", {7'd0, dut.run_press}, 8'd0);
            chk("bounce_enable",   {7'd0, enable},        8'd0);
            edge_drive();
         end
      end
      btn_run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         next_sample();
         chk("bounce_after_pulse",  {7'd0, dut.run_press}, 8'd0);
         chk("bounce_after_enable", {7'd0, enable},        8'd0);
      end

      // Run and clear together from STOP: clear wins.
      edge_drive();
      btn_run   = 1'b1;
      btn_clear = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         next_sample();
         chk("both_clear",  {7'd0, clear},  {7'd0, (i == 8)});
         chk("both_state",  {6'd0, state},  (i == 8) ? 8'd2 : 8'd0);
         chk("both_enable", {7'd0, enable}, 8'd0);
      end
      btn_run   = 1'b0;
      btn_clear = 1'b0;
      idle(10);

      // Enter RUN, then clear is ignored and mode toggles (unless locked).
      btn_run = 1'b1;
      idle(9);
      @(negedge clk);
      chk("run2_enable", {7'd0, enable}, 8'd1);
      edge_drive();
      btn_run = 1'b0;
      idle(8);
      btn_clear = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         next_sample();
         chk("run_clear_ignored", {7'd0, clear},  8'd0);
         chk("run_clear_enable",  {7'd0, enable}, 8'd1);
         chk("run_clear_state",   {6'd0, state},  8'd1);
      end
      edge_drive();
      btn_clear = 1'b0;
      idle(8);
      btn_mode = 1'b1;
      idle(12);
      @(negedge clk);
`ifdef MODE_LOCK_EN
      exp_mode = 1'b0;
`else
      exp_mode = 1'b1;
`endif
      chk("run_mode",        {7'd0, mode},   {7'd0, exp_mode});
      chk("run_mode_enable", {7'd0, enable}, 8'd1);
      edge_drive();
      btn_mode = 1'b0;
      idle(8);

      // Asynchronous reset mid-debounce while running.
      btn_run = 1'b1;
      idle(3);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_enable", {7'd0, enable}, 8'd0);
      chk("arst_clear",  {7'd0, clear},  8'd0);
      chk("arst_mode",   {7'd0, mode},   8'd0);
      chk("arst_state",  {6'd0, state},  8'd0);
      chk("arst_cnt",    {6'd0, dut.u_run.cnt}, 8'd0);
      btn_run = 1'b0;
      idle(3);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         next_sample();
         chk("post_rst_pulse", {7'd0, dut.run_press}, 8'd0);
         chk("post_rst_state", {6'd0, state},         8'd0);
      end

      // A button held through reset release still registers once.
      edge_drive();
      btn_mode = 1'b1;
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(14);
      @(negedge clk);
      chk("held_mode", {7'd0, mode}, 8'd1);
      btn_mode = 1'b0;
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_control_unit.md
COUNTER_CONTROL_UNIT -- requirements
Module: counter_control_unit

Interface
REQ-001 Parameter DB_CYCLES, default 100_000: debounce stability window in clk cycles (1 ms at 100 MHz), legal range 2..2^20.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low; flops clear on the falling edge of rst.
REQ-004 btn_run  in  1  raw run/stop push-button, asynchronous, active-high.
REQ-005 btn_clear  in  1  raw clear push-button, asynchronous, active-high.
REQ-006 btn_mode  in  1  raw up/down mode push-button, asynchronous, active-high.
REQ-007 enable  out  1  counter count enable, registered.
REQ-008 clear  out  1  counter synchronous clear, registered, one-cycle pulse.
REQ-009 mode  out  1  count direction, registered: 0 = up, 1 = down.
REQ-010 state  out  2  current FSM state, for status LEDs and the bench.

Function
REQ-011 Each button SHALL pass through its own debouncer instance:
- 2-flop synchronizer.
- Debounced level updates only after the synchronized value differs from it for DB_CYCLES consecutive cycles.
- Any bounce restarts the count.
REQ-012 Each debouncer SHALL emit a one-cycle press pulse on the clock after its debounced level rises; a release SHALL produce no pulse.
REQ-013 Latency SHALL be fixed: a clean raw rise at edge k gives a press pulse high during cycle k+2+DB_CYCLES+1, and the FSM output change is visible one cycle later.
REQ-014 FSM states SHALL be STOP=2'd0, RUN=2'd1, CLEAR=2'd2; 2'd3 is illegal and SHALL return to STOP on the next edge.
REQ-015 STOP transitions:
- clear pulse -> CLEAR.
- else run pulse -> RUN.
- else hold.
REQ-016 RUN transitions:
- run pulse -> STOP.
- clear pulse ignored; the counter cannot be cleared while running.
REQ-017 CLEAR SHALL last exactly one cycle, then go to STOP regardless of any button pulses.
REQ-018 Simultaneous run and clear pulses in STOP: clear wins and the run pulse is dropped.
REQ-019 Output decode (Moore):
- enable = 1 only in RUN.
- clear = 1 only in CLEAR.
- state reflects the state register directly.
REQ-020 Mode toggles on each mode pulse, independent of the FSM except as set by REQ-025.
- A mode pulse coincident with any FSM transition SHALL still toggle.
REQ-021 A held button SHALL produce exactly one pulse per press; auto-repeat is not allowed.

Reset
REQ-022 While rst=0, outputs SHALL be: enable=0, clear=0, mode=0 (up), state=STOP.
REQ-023 While rst=0, all synchronizer flops, debounced levels and debounce counters SHALL be 0.
REQ-024 Reset asserted mid-debounce or in RUN SHALL abort immediately with no pulse emitted.
- A button held through reset release SHALL register as a press once it is stable for DB_CYCLES.

Configuration
REQ-025 Macro MODE_LOCK_EN:
- Defined: mode pulses are ignored unless state is STOP.
- Undefined: mode toggles in any state, including RUN.

Structure
REQ-026 Package counter_cu_pkg SHALL hold:
- state encodings ST_STOP, ST_RUN, ST_CLEAR.
- the 2-bit state width.
- default DB_CYCLES constant.
REQ-027 The debouncer SHALL be sub-module btn_debounce (ports clk, rst, btn_in, level, press), instantiated three times.
REQ-028 Intended integration: outputs drive the existing counter's enable/clear/mode inputs inside the system top.

Verification (bench uses DB_CYCLES=4)
REQ-029 Reset release, no buttons, 50 cycles -> enable=0, clear=0, mode=0, state=0 throughout.
REQ-030 btn_run clean rise at edge 10 -> press pulse in cycle 17, enable=1 and state=1 from cycle 18; a second press returns enable=0 and state=0.
REQ-031 btn_run toggling every 2 cycles for 20 cycles, then low -> no press pulse, enable stays 0.
REQ-032 btn_run and btn_clear rise on the same edge in STOP -> clear=1 for exactly one cycle, state 2 then 0, enable never asserts.
REQ-033 In RUN, press btn_clear -> clear stays 0, enable stays 1; then press btn_mode -> mode=1 without MODE_LOCK_EN, mode=0 with it.
REQ-034 Drive rst low mid-debounce while in RUN with mode=1 -> enable=0, mode=0, state=0 asynchronously, and no pulse after release.
